// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and default timing/width constants for the vending output path.
package vend_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} emit_state_t;
    localparam int PULSE_HIGH_CYC = 25_000_000;
    localparam int PULSE_LOW_CYC  = 25_000_000;
    localparam int PEND_W         = 4;
    localparam int PULSE_TIMER_W  = 25;
endpackage

// File: rtl/coin_pulse_emitter_sat_add.sv
// sat_add: W-bit saturating adder with an optional decrement applied after saturation.
// Ports: a, b - addends; dec - subtract one from the saturated sum; sum - result.
module sat_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         dec,
    output logic [W-1:0] sum
);
    logic [W:0] full;
    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = (full[W] ? {W{1'b1}} : full[W-1:0]) - W'(dec);
endmodule

// File: rtl/coin_pulse_emitter.sv
// coin_pulse_emitter: turns one-cycle requests into queued, mechanically timed solenoid/LED pulses.
// Ports: clk, reset (async, active-high); req/req_count - enqueue pulses; abort - cancel outstanding;
//        pulse_out - registered drive; busy - not idle; pending - queued pulses not yet started;
//        done - one-cycle strobe when a sequence (or an abort) completes.
module coin_pulse_emitter
    import vend_pkg::*;
#(
    parameter int HIGH_CYCLES = PULSE_HIGH_CYC,
    parameter int LOW_CYCLES  = PULSE_LOW_CYC,
    parameter int CNT_W       = PEND_W,
    parameter int TIMER_W     = PULSE_TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [CNT_W-1:0] req_count,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done
);
    emit_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   next_pending;
    logic               start, relaunch, add_req;
    // abort only has meaning while busy, so it blocks a coincident req only then
    assign add_req  = req && (state == IDLE || !abort);
    assign start    = state == IDLE && req && req_count != '0;
    // a req landing on the last low cycle counts toward relaunching
    assign relaunch = state == LOW && timer == '0 && !abort &&
                      (pending != '0 || (req && req_count != '0));
    assign busy     = state != IDLE;
    sat_add #(.W(CNT_W)) u_sat_add (
        .a   (state == IDLE ? '0 : pending),
        .b   (add_req ? req_count : '0),
        .dec (start || relaunch),
        .sum (next_pending)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            pending   <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= (abort && state != IDLE) ? '0 : next_pending;
            case (state)
                IDLE: if (start) begin
                    state     <= HIGH;
                    timer     <= TIMER_W'(HIGH_CYCLES - 1);
                    pulse_out <= 1'b1;
                end
                HIGH: if (abort || timer == '0) begin
                    state     <= LOW;
                    timer     <= TIMER_W'(LOW_CYCLES - 1);
                    pulse_out <= 1'b0;
                end else begin
                    timer <= timer - 1'b1;
                end
                LOW: if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else if (relaunch) begin
                    state     <= HIGH;
                    timer     <= TIMER_W'(HIGH_CYCLES - 1);
                    pulse_out <= 1'b1;
                end else begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                end
            endcase
        end
    end
endmodule
